merge_sort_gen: RTL
===================

# merge_sort_gen

Parametrised two-way merge engine: merges two pre-sorted source arrays P (P_LEN entries) and Q (Q_LEN entries) into one sorted destination array R (P_LEN+Q_LEN entries). Source and destination memories are external; the block drives their indices and accepts one read datum per array per cycle. It is the generalised successor of the fixed 4+4 byte merge core: it has independent P/Q lengths, a configurable data width, a selectable ascending or descending order, a defined tie rule and a Done flag. It uses the same Start/Ack handshake.

## Interface
- DATA_W, 8, element width in bits
- P_LEN, 4, number of P entries; must be at least 2
- Q_LEN, 4, number of Q entries; must be at least 2
- IW, clog2(max(P_LEN,Q_LEN)), width of I and J (derived; not overridden)
- KW, clog2(P_LEN+Q_LEN), width of K (derived)

- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  begin merge; sampled only in INI
- Ack  in  1  acknowledge completion; sampled only in DONE
- Descend  in  1  0 = ascending, 1 = descending; latched on accepted Start
- Ps_of_I  in  DATA_W  P[I] from the external P memory, valid within the cycle
- Qs_of_J  in  DATA_W  Q[J] from the external Q memory, valid within the cycle
- Rs_of_K  out  DATA_W  datum to write at R[K]
- Rs_of_K_Write  out  1  write strobe for R[K]
- I  out  IW  P read index
- J  out  IW  Q read index
- K  out  KW  R write index
- Done  out  1  high while in DONE

## Operation
- The internal register `state` is one-hot, 5 bits: INI=00001, CMST=00010, RP=00100, RQ=01000, DONE=10000.
- INI: Write=0. When Start=1: clear I, J and K; latch Descend into `mode`; go to CMST.
- CMST: Write=1. Compare Ps_of_I with Qs_of_J as unsigned values.
  - Take P when P<=Q (ascending) or P>=Q (descending). On ties P wins, so the merge is stable.
  - Take P: Rs_of_K=Ps_of_I. If I==P_LEN-1, go to RQ; otherwise I++.
  - Take Q: Rs_of_K=Qs_of_J. If J==Q_LEN-1, go to RP; otherwise J++.
  - K++ on every write.
- RP: Write=1, Rs_of_K=Ps_of_I, K++. If I==P_LEN-1, go to DONE; otherwise I++.
- RQ: mirror of RP using J, Q_LEN and Qs_of_J.
- DONE: Write=0, Done=1. Indices hold their values. When Ack=1, go to INI.
- I and J never advance past their last index. K advances past P_LEN+Q_LEN-1 only on entry to DONE, where it wraps to 0 if KW allows.
- In CMST, if I and J are both at their last index, only the winner's array is exhausted. The other element is written from RQ or RP on the next cycle, so the simultaneous-last case needs no special handling.
- Start outside INI is ignored. Ack outside DONE is ignored.
- Outputs Rs_of_K and Rs_of_K_Write are combinational from `state`, `mode` and the two input data.

## Timing
- Reset asserted (asynchronously): state=INI, I=J=K=0, mode=0, Rs_of_K_Write=0, Done=0. Rs_of_K is a don't-care.
- Reset mid-merge aborts the merge immediately. R keeps any partial writes.
- Start is accepted at rising edge t0 in INI. Writes then occur on the edges at t1 through t(P_LEN+Q_LEN), one per cycle with no bubbles.
- DONE is entered at edge t(P_LEN+Q_LEN), so Done rises exactly P_LEN+Q_LEN clocks after the Start edge.
- With Ack sampled at edge ta, state=INI after ta. A new Start can be accepted at ta+1.
- External read data must settle within the same cycle as its index (combinational or asynchronous-read memory).

## Structure
- Package `merge_sort_pkg`:
  - state encodings INI, CMST, RP, RQ, DONE
  - width of the one-hot state
  - clog2 function used for IW and KW
- Sub-module `merge_sort_cmp`, parametrised on DATA_W:
  - inputs a, b, descend
  - output take_a
  - tie rule: take_a=1 when a==b
- All else in one FSM-plus-counters module.

## Test plan
- Default parameters, ascending; P={10,11,12,17}, Q={13,14,15,16} (simultaneous last index) -> R={10,11,12,13,14,15,16,17}; Done exactly 8 clocks after the Start edge.
- P={20,21,22,23}, Q={24,25,26,27} -> four CMST writes from P, then four RQ writes; R=20..27; state passes CMST->RQ->DONE.
- All eight elements = 44 -> all P written first (stable tie rule), then Q; I reaches 3 before J moves.
- Descend=1; P={9,7,5,3}, Q={8,6,4,2} -> R={9,8,7,6,5,4,3,2}. Change Descend mid-merge -> no effect on the output.
- P_LEN=3, Q_LEN=5; P={1,50,60}, Q={2,3,4,5,70} -> R={1,2,3,4,5,50,60,70}; Done after 8 clocks; K never exceeds 7 while writing.
- Drive Reset low during the 4th write -> Write=0 and state=INI with no clock edge needed. After release, Start with Ack held low -> full, correct merge. Start pulsed in DONE -> ignored until Ack.

Source files
------------

// File: rtl/merge_sort_pkg.sv
// Shared definitions for the two-way merge engine: one-hot state
// encodings and the ceiling-log2 helper used to size the index ports.
package merge_sort_pkg;

  localparam int ST_W = 5;

  localparam logic [ST_W-1:0] INI  = 5'b00001;
  localparam logic [ST_W-1:0] CMST = 5'b00010;
  localparam logic [ST_W-1:0] RP   = 5'b00100;
  localparam logic [ST_W-1:0] RQ   = 5'b01000;
  localparam logic [ST_W-1:0] DONE = 5'b10000;

  // Number of bits needed to index v entries (v >= 2).
  function automatic int ms_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/merge_sort_cmp.sv
// Element comparator for the merge engine. Unsigned compare; on equal
// elements the 'a' side wins, which keeps the merge stable.
module merge_sort_cmp #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              descend,
  output logic              take_a
);

  assign take_a = descend ? (a >= b) : (a <= b);

endmodule

// File: rtl/merge_sort_gen.sv
// Two-way merge engine: reads two pre-sorted external arrays P and Q one
// element per cycle and writes the merged sequence to external array R.
module merge_sort_gen
  import merge_sort_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int P_LEN  = 4,
  parameter int Q_LEN  = 4,
  localparam int IW    = ms_clog2((P_LEN > Q_LEN) ? P_LEN : Q_LEN),
  localparam int KW    = ms_clog2(P_LEN + Q_LEN)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Ack,
  input  logic              Descend,
  input  logic [DATA_W-1:0] Ps_of_I,
  input  logic [DATA_W-1:0] Qs_of_J,
  output logic [DATA_W-1:0] Rs_of_K,
  output logic              Rs_of_K_Write,
  output logic [IW-1:0]     I,
  output logic [IW-1:0]     J,
  output logic [KW-1:0]     K,
  output logic              Done
);

  localparam logic [IW-1:0] I_LAST = IW'(P_LEN - 1);
  localparam logic [IW-1:0] J_LAST = IW'(Q_LEN - 1);

  logic [ST_W-1:0] state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic            mode_q, mode_d;
  logic            take_p;

  // Mode is latched at Start, so a Descend change mid-merge has no effect.
  merge_sort_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .a       (Ps_of_I),
    .b       (Qs_of_J),
    .descend (mode_q),
    .take_a  (take_p)
  );

  // Next-state, index advance and the combinational R write port.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    mode_d        = mode_q;
    Rs_of_K       = Ps_of_I;
    Rs_of_K_Write = 1'b0;
    case (state_q)
      INI: begin
        if (Start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mode_d  = Descend;
          state_d = CMST;
        end
      end
      CMST: begin
        Rs_of_K_Write = 1'b1;
        k_d           = k_q + KW'(1);
        if (take_p) begin
          Rs_of_K = Ps_of_I;
          if (i_q == I_LAST) state_d = RQ;
          else               i_d     = i_q + IW'(1);
        end else begin
          Rs_of_K = Qs_of_J;
          if (j_q == J_LAST) state_d = RP;
          else               j_d     = j_q + IW'(1);
        end
      end
      RP: begin
        Rs_of_K_Write = 1'b1;
        Rs_of_K       = Ps_of_I;
        k_d           = k_q + KW'(1);
        if (i_q == I_LAST) state_d = DONE;
        else               i_d     = i_q + IW'(1);
      end
      RQ: begin
        Rs_of_K_Write = 1'b1;
        Rs_of_K       = Qs_of_J;
        k_d           = k_q + KW'(1);
        if (j_q == J_LAST) state_d = DONE;
        else               j_d     = j_q + IW'(1);
      end
      DONE: begin
        if (Ack) state_d = INI;
      end
      default: state_d = INI;
    endcase
  end

  // State, indices and mode; reset aborts any merge in progress at once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= INI;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
    end
  end

  assign I    = i_q;
  assign J    = j_q;
  assign K    = k_q;
  assign Done = (state_q == DONE);

endmodule
